// File: rtl/byte_mem_responder_if.sv
// CPU byte-serial memory bus plus the TX/RX byte-stream handshakes of byte_mem_responder.
interface byte_mem_responder_if;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  modport master (
    output rdy_in, mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
    input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready
  );

  modport slave (
    input  rdy_in, mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
    output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/byte_mem_responder.sv
// Byte RAM below IO_BASE plus memory-mapped TX/RX FIFOs at IO_BASE; one byte per cycle,
// read data registered one cycle after the address.
module byte_mem_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          FIFO_WIDTH = 3
) (
  input logic                 clk_in,
  input logic                 rst_in,
  byte_mem_responder_if.slave bus
);
  localparam int                    RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [FIFO_WIDTH:0]   CNT_ZERO  = {(FIFO_WIDTH+1){1'b0}};
  localparam logic [FIFO_WIDTH:0]   CNT_ONE   = (FIFO_WIDTH+1)'(1);
  localparam logic [FIFO_WIDTH:0]   CNT_FULL  = (FIFO_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH:0]   CNT_NEAR  = (FIFO_WIDTH+1)'(FIFO_DEPTH - 2);
  localparam logic [FIFO_WIDTH-1:0] PTR_ZERO  = {FIFO_WIDTH{1'b0}};
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE   = FIFO_WIDTH'(1);
  localparam logic [31:0]           OFF_DATA  = 32'd0;
  localparam logic [31:0]           OFF_STAT  = 32'd4;

  logic [7:0] ram_q    [RAM_DEPTH];
  logic [7:0] tx_mem_q [FIFO_DEPTH];
  logic [7:0] rx_mem_q [FIFO_DEPTH];

  logic [FIFO_WIDTH-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [FIFO_WIDTH-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [FIFO_WIDTH:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                  ovf_q, ovf_d, io_full_q, io_full_d;
  logic [7:0]            din_q, din_d;

  logic                  is_io, sel_data, sel_stat;
  logic [31:0]           io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  tx_full, tx_nonempty, rx_nonempty;
  logic                  tx_pop, tx_push, cpu_tx_wr, ovf_set, ovf_clr;
  logic                  rx_push, rx_pop, ram_we;
  logic [7:0]            status;

  // Address decode and per-cycle FIFO/RAM strobes
  always_comb begin
    is_io       = (bus.mem_a >= IO_BASE);
    io_off      = bus.mem_a - IO_BASE;
    ram_idx     = bus.mem_a[ADDR_WIDTH-1:0];
    sel_data    = is_io && (io_off == OFF_DATA);
    sel_stat    = is_io && (io_off == OFF_STAT);
    tx_full     = (tx_cnt_q == CNT_FULL);
    tx_nonempty = (tx_cnt_q != CNT_ZERO);
    rx_nonempty = (rx_cnt_q != CNT_ZERO);
    status      = {5'b00000, ovf_q, rx_nonempty, tx_full};
    tx_pop      = tx_nonempty && bus.tx_ready;
    cpu_tx_wr   = bus.rdy_in && bus.mem_wr && sel_data;
    // A full TX FIFO still accepts a store when its head leaves in the same cycle
    tx_push     = cpu_tx_wr && (!tx_full || tx_pop);
    ovf_set     = cpu_tx_wr && !tx_push;
    ovf_clr     = bus.rdy_in && bus.mem_wr && sel_stat && bus.mem_dout[0];
    rx_push     = bus.rx_valid && (rx_cnt_q != CNT_FULL);
    rx_pop      = bus.rdy_in && !bus.mem_wr && sel_data && rx_nonempty;
    ram_we      = bus.rdy_in && bus.mem_wr && !is_io;
  end

  // Next-state for pointers, counts, overflow flag and read data
  always_comb begin
    tx_rd_d = tx_pop  ? (tx_rd_q + PTR_ONE) : tx_rd_q;
    tx_wr_d = tx_push ? (tx_wr_q + PTR_ONE) : tx_wr_q;
    rx_rd_d = rx_pop  ? (rx_rd_q + PTR_ONE) : rx_rd_q;
    rx_wr_d = rx_push ? (rx_wr_q + PTR_ONE) : rx_wr_q;

    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase

    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    io_full_d = (tx_cnt_d >= CNT_NEAR);

    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    din_d = din_q;
    if (!bus.rdy_in) begin
      din_d = din_q;
    end else if (bus.mem_wr) begin
      din_d = 8'h00;
    end else if (!is_io) begin
      din_d = ram_q[ram_idx];
    end else if (sel_data) begin
      din_d = rx_pop ? rx_mem_q[rx_rd_q] : 8'h00;
    end else if (sel_stat) begin
      din_d = status;
    end else begin
      din_d = 8'h00;
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tx_rd_q   <= PTR_ZERO;
      tx_wr_q   <= PTR_ZERO;
      rx_rd_q   <= PTR_ZERO;
      rx_wr_q   <= PTR_ZERO;
      tx_cnt_q  <= CNT_ZERO;
      rx_cnt_q  <= CNT_ZERO;
      ovf_q     <= 1'b0;
      io_full_q <= 1'b0;
      din_q     <= 8'h00;
    end else begin
      tx_rd_q   <= tx_rd_d;
      tx_wr_q   <= tx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_wr_q   <= rx_wr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      ovf_q     <= ovf_d;
      io_full_q <= io_full_d;
      din_q     <= din_d;
    end
  end

  // Storage arrays are never cleared, but reset blocks any write in its cycle
  always_ff @(posedge clk_in) begin
    if (rst_in && ram_we) begin
      ram_q[ram_idx] <= bus.mem_dout;
    end
    if (rst_in && tx_push) begin
      tx_mem_q[tx_wr_q] <= bus.mem_dout;
    end
    if (rst_in && rx_push) begin
      rx_mem_q[rx_wr_q] <= bus.rx_data;
    end
  end

  assign bus.mem_din        = din_q;
  assign bus.io_buffer_full = io_full_q;
  assign bus.tx_valid       = tx_nonempty;
  assign bus.tx_data        = tx_mem_q[tx_rd_q];
  assign bus.rx_ready       = (rx_cnt_q != CNT_FULL);
endmodule

// File: tb/tb_byte_mem_responder.sv
// Scoreboard bench for byte_mem_responder: a queue-level reference model predicts read data,
// TX bytes and flag outputs; a negedge monitor pops and compares.
module tb_byte_mem_responder;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [31:0] IO_STAT = 32'h0003_0004;
  localparam logic [31:0] RAM_MOD = 32'h0002_0000;

  logic clk_in = 1'b0;
  logic rst_in;
  byte_mem_responder_if bus();

  byte_mem_responder #(
    .ADDR_WIDTH(17), .IO_BASE(IO_BASE), .FIFO_DEPTH(8), .FIFO_WIDTH(3)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int due; logic [7:0] val; } din_exp_t;

  logic [7:0] ram_m [int];
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  logic [7:0] tx_exp[$];
  din_exp_t   din_q[$];
  logic       ovf_m = 1'b0;
  logic [7:0] din_m = 8'h00;
  logic       din_known = 1'b0;
  logic       model_ok = 1'b0;
  logic       g_txr = 1'b0;
  logic       g_rxv = 1'b0;
  logic [7:0] g_rxd = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One bus cycle: check flag outputs against the model, drive inputs, advance the model.
  task automatic cycle(input logic rst, input logic rdy, input logic wr,
                       input logic [31:0] a, input logic [7:0] d);
    logic        tx_pop, push_tx, set_o, clr_o;
    logic [7:0]  status;
    logic [31:0] off;
    int          rx_pre, key;
    @(posedge clk_in); #1;
    if (model_ok) begin
      chk("tx_valid", 32'(bus.tx_valid), 32'(tx_m.size() != 0));
      chk("rx_ready", 32'(bus.rx_ready), 32'(rx_m.size() != 8));
      chk("io_buffer_full", 32'(bus.io_buffer_full), 32'(tx_m.size() >= 6));
      if (tx_m.size() != 0) chk("tx_head", 32'(bus.tx_data), 32'(tx_m[0]));
    end
    rst_in       = rst;
    bus.rdy_in   = rdy;
    bus.mem_wr   = wr;
    bus.mem_a    = a;
    bus.mem_dout = d;
    bus.tx_ready = g_txr;
    bus.rx_valid = g_rxv;
    bus.rx_data  = g_rxd;
    if (!rst) begin
      tx_m.delete();
      rx_m.delete();
      ovf_m     = 1'b0;
      din_m     = 8'h00;
      din_known = 1'b1;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      tx_pop  = g_txr && (tx_m.size() != 0);
      status  = {5'b00000, ovf_m, rx_m.size() != 0, tx_m.size() == 8};
      rx_pre  = rx_m.size();
      push_tx = 1'b0;
      set_o   = 1'b0;
      clr_o   = 1'b0;
      if (rdy) begin
        if (a < IO_BASE) begin
          key = int'(a % RAM_MOD);
          if (wr) begin
            ram_m[key] = d;
            din_m = 8'h00;
            din_known = 1'b1;
          end else if (ram_m.exists(key)) begin
            din_m = ram_m[key];
            din_known = 1'b1;
          end else begin
            din_known = 1'b0;
          end
        end else begin
          off = a - IO_BASE;
          din_known = 1'b1;
          if (wr) begin
            din_m = 8'h00;
            if (off == 32'd0) push_tx = 1'b1;
            else if (off == 32'd4) clr_o = d[0];
          end else if (off == 32'd0) begin
            if (rx_pre != 0) din_m = rx_m.pop_front();
            else din_m = 8'h00;
          end else if (off == 32'd4) begin
            din_m = status;
          end else begin
            din_m = 8'h00;
          end
        end
      end
      if (tx_pop) tx_exp.push_back(tx_m.pop_front());
      if (push_tx) begin
        if (tx_m.size() < 8) tx_m.push_back(d);
        else set_o = 1'b1;
      end
      if (clr_o) ovf_m = 1'b0;
      if (set_o) ovf_m = 1'b1;
      if (g_rxv && rx_pre < 8) rx_m.push_back(g_rxd);
    end
    if (model_ok && din_known) din_q.push_back('{due: cyc + 1, val: din_m});
  endtask

  task automatic wr_b(input logic [31:0] a, input logic [7:0] d);
    cycle(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd_b(input logic [31:0] a);
    cycle(1'b1, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  // Monitor: read data and TX handshakes compared against scoreboard queues
  always @(negedge clk_in) begin
    din_exp_t e;
    if (din_q.size() != 0 && din_q[0].due == cyc) begin
      e = din_q.pop_front();
      chk("mem_din", 32'(bus.mem_din), 32'(e.val));
    end
    if (rst_in === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      if (tx_exp.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tx_extra @cyc %0d: got byte 0x%0h, want no transfer", cyc, bus.tx_data);
      end else begin
        chk("tx_data", 32'(bus.tx_data), 32'(tx_exp.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  d;
    logic        wr, rdy;
    rst_in = 1'b0;
    bus.rdy_in = 1'b0; bus.mem_a = 32'h0; bus.mem_wr = 1'b0; bus.mem_dout = 8'h00;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200, 8'hFF);

    // RAM, latency and aliasing
    wr_b(32'h0000_0100, 8'hA5);
    wr_b(32'h0000_0101, 8'h3C);
    rd_b(32'h0000_0100);
    rd_b(32'h0000_0101);
    wr_b(32'h0002_0102, 8'h77);
    rd_b(32'h0000_0102);
    wr_b(32'h0000_0200, 8'h42);

    // TX fill, overflow, clear, unmapped offsets, drain
    g_txr = 1'b0;
    for (int i = 0; i < 8; i++) wr_b(IO_BASE, 8'($urandom));
    wr_b(IO_BASE, 8'hEE);
    rd_b(IO_STAT);
    wr_b(IO_STAT, 8'h01);
    rd_b(IO_STAT);
    rd_b(IO_BASE + 32'd8);
    wr_b(IO_BASE + 32'd8, 8'hFF);
    g_txr = 1'b1;
    repeat (9) idle();
    g_txr = 1'b0;

    // RX push then CPU pops, including empty read
    g_rxv = 1'b1;
    g_rxd = 8'h11; idle();
    g_rxd = 8'h22; idle();
    g_rxd = 8'h33; idle();
    g_rxv = 1'b0;
    rd_b(IO_STAT);
    repeat (4) rd_b(IO_BASE);
    rd_b(IO_STAT);

    // Full TX with simultaneous pop; RX at 7 with simultaneous push/pop; RX full
    for (int i = 0; i < 8; i++) wr_b(IO_BASE, 8'($urandom));
    g_txr = 1'b1;
    wr_b(IO_BASE, 8'h5A);
    g_txr = 1'b0;
    rd_b(IO_STAT);
    g_txr = 1'b1;
    repeat (9) idle();
    g_txr = 1'b0;
    g_rxv = 1'b1;
    for (int i = 0; i < 7; i++) begin g_rxd = 8'($urandom); idle(); end
    g_rxd = 8'hC7;
    rd_b(IO_BASE);
    for (int i = 0; i < 3; i++) begin g_rxd = 8'($urandom); idle(); end
    g_rxv = 1'b0;
    repeat (9) rd_b(IO_BASE);

    // rdy_in low holds everything; reset mid drain with overflow set
    rd_b(32'h0000_0100);
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 32'h0000_0200, 8'hEE);
    rd_b(32'h0000_0200);
    for (int i = 0; i < 9; i++) wr_b(IO_BASE, 8'($urandom));
    g_txr = 1'b1;
    idle(); idle();
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200, 8'h99);
    g_txr = 1'b0;
    idle();
    rd_b(IO_STAT);
    rd_b(32'h0000_0200);

    // Randomised traffic through both FIFOs and RAM
    for (int i = 0; i < 300; i++) begin
      g_txr = ($urandom_range(0, 2) != 0);
      g_rxv = ($urandom_range(0, 1) != 0);
      g_rxd = 8'($urandom);
      rdy   = ($urandom_range(0, 4) != 0);
      d     = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: begin wr = 1'b1; a = IO_BASE; end
        3, 4:    begin wr = 1'b0; a = IO_BASE; end
        5:       begin wr = 1'b0; a = IO_STAT; end
        6:       begin wr = 1'b1; a = IO_STAT; end
        7:       begin wr = 1'b1; a = 32'h300 + $urandom_range(0, 7) + ($urandom_range(0, 1) * RAM_MOD); end
        8:       begin wr = 1'b0; a = 32'h300 + $urandom_range(0, 7) + ($urandom_range(0, 1) * RAM_MOD); end
        default: begin wr = 1'($urandom_range(0, 1)); a = IO_BASE + 32'd4 * $urandom_range(2, 5); end
      endcase
      cycle(1'b1, rdy, wr, a, d);
    end
    g_rxv = 1'b0;
    g_txr = 1'b1;
    repeat (12) idle();
    g_txr = 1'b0;
    repeat (10) rd_b(IO_BASE);
    idle();
    repeat (2) @(negedge clk_in);
    #1;
    chk("tx_scoreboard_left", 32'(tx_exp.size()), 32'd0);
    chk("din_scoreboard_left", 32'(din_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
